collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
Collision detector for the player character. It produces the contact flags and the contact-object word that the character physics block consumes once per frame. On each start pulse it latches the character position and scans the level's platform table one entry per two cycles. It reports the first object the character is touching or embedded in, with per-side contact flags. Results are registered and held stable until the next scan completes, so physics can sample them on its own frame tick.

Parameters:
NUM_OBJ, 8, number of platform entries in the level table (>=1).
ADDR_W, 3, width of obj_addr; must satisfy 2**ADDR_W >= NUM_OBJ.
CHAR_W, 10, character box width in pixels (signed).
CHAR_H, 20, character box height in pixels (signed).
MARGIN, 3, contact tolerance band in pixels for each side test.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle scan request; honoured only in IDLE.
x  in  11  signed character left x, sampled on accepted start.
y  in  10  signed character top y, sampled on accepted start.
obj_addr  out  ADDR_W  platform table read address.
obj_data  in  44  table word {left[43:33], top[32:22], right[21:11], bottom[10:0]}, unsigned; valid 1 cycle after obj_addr.
upC  out  1  character head is on the object's bottom face.
downC  out  1  character feet are on the object's top face.
leftC  out  1  character left side is on the object's right face.
rightC  out  1  character right side is on the object's left face.
collided_object  out  44  copy of the obj_data word that produced the flags; 0 if no hit.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse; outputs are updated in this same cycle.

Behaviour:
- Reset: state IDLE, obj_addr=0, all flags 0, collided_object=0, busy=0, done=0, latched x/y=0. Reset mid-scan aborts the scan with no done pulse.
- States:
  - IDLE: on start, latch x and y, set obj_addr=0, go to READ.
  - READ: one wait cycle for synchronous table data, then go to CMP.
  - CMP: evaluate obj_data.
    - Any flag set: register the flags and the word, go to DONE (early termination).
    - No flag and obj_addr==NUM_OBJ-1: register all flags 0 and collided_object=0, go to DONE.
    - Otherwise: obj_addr+1, go to READ.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in READ, CMP and DONE.
- start outside IDLE is ignored, including start in the DONE cycle.
- Latency: with start high in cycle 0 and a hit at index k, done is high in cycle 3+2k. With no hit, done is high in cycle 2*NUM_OBJ+1.
- Flags, collided_object and obj_addr change only as specified; they hold between scans.
- Arithmetic:
  - All comparisons are done in 13-bit signed. x and y are sign-extended; object fields are zero-extended.
  - Let L, T, R, B be the object's left, top, right and bottom fields.
  - Let cr=x+CHAR_W and cb=y+CHAR_H.
  - ovx = (cr>L) & (x<R).
  - ovy = (cb>T) & (y<B).
- Side tests, evaluated simultaneously; several may be set for one object:
  - downC = ovx & (cb+1 >= T) & (cb+1 <= T+MARGIN).
  - upC = ovx & (y-1 <= B) & (y-1 >= B-MARGIN).
  - rightC = ovy & (cr+1 >= L) & (cr+1 <= L+MARGIN).
  - leftC = ovy & (x-1 <= R) & (x-1 >= R-MARGIN).
- Boundary rules:
  - Exactly touching (feet row = T-1, i.e. cb+1==T) counts as downC. This is the rest position physics writes after a landing.
  - Objects are reported in table order; the lowest index wins.
  - Negative x or y is legal. Entries with left>right or top>bottom are never hit, because ovx or ovy is false.

Test Plan:
- Table[0]={0,400,639,479}, start with x=30,y=379 -> done in cycle 3; downC=1, others 0; collided_object={0,400,639,479}.
- Table[0] far away {600,0,610,10}, table[1]={100,300,110,479}, x=89,y=350 -> done in cycle 5; rightC=1 only; collided_object=table[1].
- Character at x=200,y=100 clear of all 8 entries -> done in cycle 17; all flags 0; collided_object=0; busy high cycles 1-17.
- Entries 2 and 5 both touching the character -> entry 2 reported, done in cycle 7; entry 5 never compared (obj_addr never exceeds 2).
- Reset asserted in cycle 4 of a scan -> no done pulse; outputs 0 next cycle. A new start afterwards completes normally.
- start pulsed again in cycles 2 and the DONE cycle -> ignored. Only one done pulse; x/y from the first start are used.

Source files
------------

// File: rtl/collision_detector_if.sv
// Bus between the collision detector and its surroundings.
//
// Purpose: groups the scan request, the platform-table read port and the
// contact results into one bundle.
//
// Signals:
//   start           scan request pulse (master -> detector)
//   x, y            signed character top-left position (master -> detector)
//   obj_addr        platform table read address (detector -> master)
//   obj_data        table word {left, top, right, bottom}, one cycle after obj_addr
//   upC/downC/...   per-side contact flags (detector -> master)
//   collided_object table word that produced the flags, 0 on no hit
//   busy, done      scan status (detector -> master)
//
// Modports:
//   master  the frame logic / table owner driving requests and table data
//   slave   the collision detector itself
interface collision_detector_if #(
  parameter int unsigned ADDR_W = 3
);
  logic                start;
  logic signed [10:0]  x;
  logic signed [9:0]   y;
  logic [ADDR_W-1:0]   obj_addr;
  logic [43:0]         obj_data;
  logic                upC;
  logic                downC;
  logic                leftC;
  logic                rightC;
  logic [43:0]         collided_object;
  logic                busy;
  logic                done;

  modport master (
    output start, x, y, obj_data,
    input  obj_addr, upC, downC, leftC, rightC, collided_object, busy, done
  );

  modport slave (
    input  start, x, y, obj_data,
    output obj_addr, upC, downC, leftC, rightC, collided_object, busy, done
  );
endinterface

// File: rtl/collision_detector.sv
// Player-character collision detector.
//
// Purpose: on an accepted start, latches the character position and walks the
// level's platform table (one entry every two cycles, the table read is
// synchronous), reporting the first entry the character touches or is embedded
// in together with per-side contact flags. Results are registered and held
// until the next scan completes so physics can sample them at any time.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset; aborts a scan without a done pulse
//   io_bus  collision_detector_if.slave: start/x/y request, obj_addr/obj_data
//           table port, upC/downC/leftC/rightC flags, collided_object,
//           busy and done status
module collision_detector #(
  parameter int          NUM_OBJ = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int          CHAR_W  = 10,
  parameter int          CHAR_H  = 20,
  parameter int          MARGIN  = 3
) (
  input logic                  clk,
  input logic                  reset,
  collision_detector_if.slave  io_bus
);

  // All geometry is evaluated in 13-bit signed so that negative positions and
  // the +CHAR/+MARGIN offsets of 11-bit coordinates never wrap.
  localparam logic signed [12:0] LP_CHAR_W = 13'(CHAR_W);
  localparam logic signed [12:0] LP_CHAR_H = 13'(CHAR_H);
  localparam logic signed [12:0] LP_MARGIN = 13'(MARGIN);
  localparam logic signed [12:0] LP_ONE    = 13'sd1;
  localparam logic [ADDR_W-1:0]  LP_LAST   = ADDR_W'(NUM_OBJ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StCmp,
    StDone
  } state_e;

  state_e             r_state, w_state_next;
  logic signed [10:0] r_x, w_x_next;
  logic signed [9:0]  r_y, w_y_next;
  logic [ADDR_W-1:0]  r_obj_addr, w_obj_addr_next;
  logic               r_up, w_up_next;
  logic               r_down, w_down_next;
  logic               r_left, w_left_next;
  logic               r_right, w_right_next;
  logic [43:0]        r_coll, w_coll_next;

  // ---------------------------------------------------------------------------
  // Geometry of the latched character against the current table word
  // ---------------------------------------------------------------------------
  logic signed [12:0] w_xs, w_ys;
  logic signed [12:0] w_l, w_t, w_r, w_b;
  logic signed [12:0] w_cr, w_cb;
  logic signed [12:0] w_cr_p1, w_cb_p1, w_x_m1, w_y_m1;
  logic signed [12:0] w_l_pm, w_t_pm, w_r_mm, w_b_mm;
  logic               w_ovx, w_ovy;
  logic               w_hit_up, w_hit_down, w_hit_left, w_hit_right;
  logic               w_hit_any;

  always_comb begin
    // Character position is signed, table fields are unsigned.
    w_xs = {{2{r_x[10]}}, r_x};
    w_ys = {{3{r_y[9]}}, r_y};
    w_l  = {2'b00, io_bus.obj_data[43:33]};
    w_t  = {2'b00, io_bus.obj_data[32:22]};
    w_r  = {2'b00, io_bus.obj_data[21:11]};
    w_b  = {2'b00, io_bus.obj_data[10:0]};

    w_cr = w_xs + LP_CHAR_W;
    w_cb = w_ys + LP_CHAR_H;

    w_cr_p1 = w_cr + LP_ONE;
    w_cb_p1 = w_cb + LP_ONE;
    w_x_m1  = w_xs - LP_ONE;
    w_y_m1  = w_ys - LP_ONE;

    w_l_pm = w_l + LP_MARGIN;
    w_t_pm = w_t + LP_MARGIN;
    w_r_mm = w_r - LP_MARGIN;
    w_b_mm = w_b - LP_MARGIN;

    // Inverted entries (left>right or top>bottom) fail these and never hit.
    w_ovx = (w_cr > w_l) && (w_xs < w_r);
    w_ovy = (w_cb > w_t) && (w_ys < w_b);

    // Each side test accepts the exact touching row/column (one pixel outside
    // the face) plus MARGIN pixels of penetration.
    w_hit_down  = w_ovx && (w_cb_p1 >= w_t) && (w_cb_p1 <= w_t_pm);
    w_hit_up    = w_ovx && (w_y_m1 <= w_b) && (w_y_m1 >= w_b_mm);
    w_hit_right = w_ovy && (w_cr_p1 >= w_l) && (w_cr_p1 <= w_l_pm);
    w_hit_left  = w_ovy && (w_x_m1 <= w_r) && (w_x_m1 >= w_r_mm);

    w_hit_any = w_hit_up | w_hit_down | w_hit_left | w_hit_right;
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_x_next        = r_x;
    w_y_next        = r_y;
    w_obj_addr_next = r_obj_addr;
    w_up_next       = r_up;
    w_down_next     = r_down;
    w_left_next     = r_left;
    w_right_next    = r_right;
    w_coll_next     = r_coll;

    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_x_next        = io_bus.x;
          w_y_next        = io_bus.y;
          w_obj_addr_next = '0;
          w_state_next    = StRead;
        end
      end

      // Table data for obj_addr arrives one cycle after the address.
      StRead: begin
        w_state_next = StCmp;
      end

      StCmp: begin
        if (w_hit_any) begin
          // First hit in table order wins; stop scanning.
          w_up_next    = w_hit_up;
          w_down_next  = w_hit_down;
          w_left_next  = w_hit_left;
          w_right_next = w_hit_right;
          w_coll_next  = io_bus.obj_data;
          w_state_next = StDone;
        end else if (r_obj_addr == LP_LAST) begin
          w_up_next    = 1'b0;
          w_down_next  = 1'b0;
          w_left_next  = 1'b0;
          w_right_next = 1'b0;
          w_coll_next  = '0;
          w_state_next = StDone;
        end else begin
          w_obj_addr_next = r_obj_addr + ADDR_W'(1);
          w_state_next    = StRead;
        end
      end

      // start is deliberately not looked at here.
      StDone: begin
        w_state_next = StIdle;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_x        <= '0;
      r_y        <= '0;
      r_obj_addr <= '0;
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_coll     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_x        <= w_x_next;
      r_y        <= w_y_next;
      r_obj_addr <= w_obj_addr_next;
      r_up       <= w_up_next;
      r_down     <= w_down_next;
      r_left     <= w_left_next;
      r_right    <= w_right_next;
      r_coll     <= w_coll_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io_bus.obj_addr        = r_obj_addr;
  assign io_bus.upC             = r_up;
  assign io_bus.downC           = r_down;
  assign io_bus.leftC           = r_left;
  assign io_bus.rightC          = r_right;
  assign io_bus.collided_object = r_coll;
  assign io_bus.busy            = (r_state != StIdle);
  assign io_bus.done            = (r_state == StDone);

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: a table of single-object
// vectors plus hand-written multi-cycle sequences (no-hit scan, priority,
// mid-scan reset, ignored start pulses).
module tb_collision_detector;

  localparam int NOBJ = 8;

  logic clk;
  logic reset;

  collision_detector_if #(.ADDR_W(3)) bus ();

  collision_detector #(
    .NUM_OBJ(NOBJ),
    .ADDR_W (3),
    .CHAR_W (10),
    .CHAR_H (20),
    .MARGIN (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous platform table.
  logic [43:0] mem [NOBJ];
  always @(posedge clk) bus.obj_data <= mem[bus.obj_addr];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [43:0] mk(input int l, input int t, input int r, input int b);
    mk = {11'(l), 11'(t), 11'(r), 11'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    flags = {bus.upC, bus.downC, bus.leftC, bus.rightC};
  endfunction

  task automatic fill(input logic [43:0] w);
    for (int i = 0; i < NOBJ; i++) mem[i] = w;
  endtask

  // Starts a scan in cycle 0 and observes cycles 1..40. Extra start pulses
  // (with a different position) are driven in cycles p1 and p2.
  task automatic run_scan(input logic signed [10:0] sx, input logic signed [9:0] sy,
                          input int exp_done, input int p1, input int p2,
                          output int first_done, output int n_done,
                          output int max_addr, output int busy_bad);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x = sx;
    bus.y = sy;
    first_done = -1;
    n_done = 0;
    max_addr = 0;
    busy_bad = 0;
    if (bus.busy !== 1'b0) busy_bad++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (int'(bus.obj_addr) > max_addr) max_addr = int'(bus.obj_addr);
      if (bus.busy !== (c <= exp_done)) busy_bad++;
      if (c == p1 || c == p2) begin
        bus.start = 1'b1;
        bus.x = 11'sd500;
        bus.y = 10'sd0;
      end
    end
  endtask

  typedef struct {
    logic signed [10:0] x;
    logic signed [9:0]  y;
    int                 k;
    logic [43:0]        obj;
    logic [3:0]         fl;   // {up, down, left, right}
    bit                 hit;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [43:0] filler, ground;
    int fd, nd, ma, bb, exp_done;

    filler = mk(2000, 2000, 2010, 2010);
    ground = mk(0, 400, 639, 479);

    vecs[0]  = '{x: 11'sd30,  y: 10'sd379, k: 0, obj: ground,                    fl: 4'b0100, hit: 1};
    vecs[1]  = '{x: 11'sd89,  y: 10'sd350, k: 1, obj: mk(100, 300, 110, 479),    fl: 4'b0001, hit: 1};
    vecs[2]  = '{x: 11'sd150, y: 10'sd51,  k: 3, obj: mk(100, 0, 300, 50),       fl: 4'b1000, hit: 1};
    vecs[3]  = '{x: 11'sd101, y: 10'sd350, k: 7, obj: mk(0, 300, 100, 479),      fl: 4'b0010, hit: 1};
    vecs[4]  = '{x: 11'sd30,  y: 10'sd381, k: 0, obj: ground,                    fl: 4'b0100, hit: 1};
    vecs[5]  = '{x: 11'sd30,  y: 10'sd382, k: 0, obj: ground,                    fl: 4'b0100, hit: 1};
    vecs[6]  = '{x: 11'sd30,  y: 10'sd383, k: 0, obj: ground,                    fl: 4'b0000, hit: 0};
    vecs[7]  = '{x: 11'sd30,  y: 10'sd378, k: 0, obj: ground,                    fl: 4'b0000, hit: 0};
    vecs[8]  = '{x: -11'sd10, y: 10'sd100, k: 2, obj: mk(0, 0, 100, 479),        fl: 4'b0001, hit: 1};
    vecs[9]  = '{x: 11'sd91,  y: 10'sd81,  k: 4, obj: mk(100, 100, 200, 200),    fl: 4'b0101, hit: 1};
    vecs[10] = '{x: 11'sd150, y: 10'sd79,  k: 5, obj: mk(200, 100, 100, 200),    fl: 4'b0000, hit: 0};
    vecs[11] = '{x: 11'sd50,  y: -10'sd21, k: 6, obj: mk(0, 0, 100, 100),        fl: 4'b0100, hit: 1};

    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    fill(filler);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset flags", 64'(flags()), 64'(4'b0000));
    chk("reset collided", 64'(bus.collided_object), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset obj_addr", 64'(bus.obj_addr), 64'(0));
    reset = 1'b0;

    // Table-driven single-object vectors.
    foreach (vecs[i]) begin
      fill(filler);
      mem[vecs[i].k] = vecs[i].obj;
      exp_done = vecs[i].hit ? 3 + 2 * vecs[i].k : 2 * NOBJ + 1;
      run_scan(vecs[i].x, vecs[i].y, exp_done, -1, -1, fd, nd, ma, bb);
      chk($sformatf("v%0d done cycle", i), 64'(fd), 64'(exp_done));
      chk($sformatf("v%0d done count", i), 64'(nd), 64'(1));
      chk($sformatf("v%0d flags", i), 64'(flags()), 64'(vecs[i].fl));
      chk($sformatf("v%0d collided", i), 64'(bus.collided_object),
          64'(vecs[i].hit ? vecs[i].obj : 44'd0));
    end

    // Clear of all eight varied entries: full-length scan.
    mem[0] = ground;
    mem[1] = mk(600, 0, 610, 10);
    mem[2] = mk(300, 50, 250, 200);
    mem[3] = mk(215, 0, 300, 479);
    mem[4] = mk(0, 0, 195, 479);
    mem[5] = mk(150, 0, 250, 95);
    mem[6] = mk(150, 125, 250, 300);
    mem[7] = mk(0, 0, 0, 0);
    run_scan(11'sd200, 10'sd100, 17, -1, -1, fd, nd, ma, bb);
    chk("clear done cycle", 64'(fd), 64'(17));
    chk("clear busy window", 64'(bb), 64'(0));
    chk("clear flags", 64'(flags()), 64'(0));
    chk("clear collided", 64'(bus.collided_object), 64'(0));
    chk("clear max addr", 64'(ma), 64'(7));

    // Two touching entries: the lower index wins, scan stops there.
    fill(filler);
    mem[2] = ground;
    mem[5] = mk(10, 400, 600, 479);
    run_scan(11'sd30, 10'sd379, 7, -1, -1, fd, nd, ma, bb);
    chk("prio done cycle", 64'(fd), 64'(7));
    chk("prio flags", 64'(flags()), 64'(4'b0100));
    chk("prio collided", 64'(bus.collided_object), 64'(ground));
    chk("prio max addr", 64'(ma), 64'(2));

    // Reset in cycle 4 of a no-hit scan; previous results are non-zero.
    fill(filler);
    nd = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x = 11'sd30;
    bus.y = 10'sd379;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) nd++;
    end
    chk("pre-reset obj_addr", 64'(bus.obj_addr), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort flags", 64'(flags()), 64'(0));
    chk("abort collided", 64'(bus.collided_object), 64'(0));
    chk("abort busy", 64'(bus.busy), 64'(0));
    chk("abort obj_addr", 64'(bus.obj_addr), 64'(0));
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) nd++;
    end
    chk("abort no done", 64'(nd), 64'(0));

    fill(filler);
    mem[0] = ground;
    run_scan(11'sd30, 10'sd379, 3, -1, -1, fd, nd, ma, bb);
    chk("post-reset done cycle", 64'(fd), 64'(3));
    chk("post-reset flags", 64'(flags()), 64'(4'b0100));
    chk("post-reset collided", 64'(bus.collided_object), 64'(ground));

    // Start pulses in cycle 2 and in the DONE cycle are ignored.
    fill(filler);
    mem[2] = ground;
    run_scan(11'sd30, 10'sd379, 7, 2, 7, fd, nd, ma, bb);
    chk("restart done cycle", 64'(fd), 64'(7));
    chk("restart done count", 64'(nd), 64'(1));
    chk("restart busy window", 64'(bb), 64'(0));
    chk("restart flags", 64'(flags()), 64'(4'b0100));
    chk("restart collided", 64'(bus.collided_object), 64'(ground));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
